codificador_instrucoes: RTL and testbench
=========================================

CODIFICADOR_INSTRUCOES -- requirements
Module: codificador_instrucoes

Interface
REQ-001 SHALL have parameter MEM_PALAVRAS, default 51, meaning instruction-memory capacity in 32-bit words.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port reinicia  input  1  synchronous restart of the write pointer.
REQ-005 SHALL have port in_valid  input  1  field set offered.
REQ-006 SHALL have port in_ready  output  1  field set accepted when in_valid&&in_ready.
REQ-007 SHALL have ports opcode[6:0], funct3[2:0], funct7[6:0], rs1[4:0], rs2[4:0], rd[4:0] and imediato[11:0], all inputs carrying the instruction fields.
REQ-008 SHALL have port mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-009 SHALL have port mem_addr  output  32  byte address, word-aligned.
REQ-010 SHALL have port mem_wdata  output  32  encoded instruction.
REQ-011 SHALL have port cheio  output  1  memory full.
REQ-012 SHALL have port erro  output  1  one-cycle pulse on a rejected field set.
REQ-013 SHALL have port contador  output  6  number of words written.

Function
REQ-014 SHALL implement FSM states OCIOSO, ESCREVE and CHEIO.
REQ-015 SHALL drive in_ready=1 only in OCIOSO.
REQ-016 SHALL, on a handshake in OCIOSO with a legal opcode, register the encoded word and go to ESCREVE.
REQ-017 SHALL, in ESCREVE, assert mem_we for exactly one cycle with mem_addr=contador*4; next cycle contador increments and the FSM goes to CHEIO if contador==MEM_PALAVRAS, else OCIOSO; handshake-to-write latency is 1 cycle.
REQ-018 SHALL encode R-type (0110011: ADD/OR/SLL) as {funct7,rs2,rs1,funct3,rd,opcode}.
REQ-019 SHALL encode I-type (0010011 ADDI, 0000011 LH) as {imediato,rs1,funct3,rd,opcode}.
REQ-020 SHALL encode S-type (0100011 SH) and B-type (1100011 BNE) as {imediato[11:5],rs2,rs1,funct3,imediato[4:0],opcode}, exactly inverting the decoder's field extraction.
REQ-021 SHALL, on any other opcode, pulse erro for one cycle after the handshake, perform no write, leave contador unchanged and stay in OCIOSO.
REQ-022 SHALL, in CHEIO, hold cheio=1 and in_ready=0 and ignore in_valid.
REQ-023 SHALL, on reinicia from any state, clear contador and go to OCIOSO next cycle; a pending ESCREVE write is suppressed, and reinicia wins over a simultaneous handshake.
REQ-024 SHALL hold mem_addr and mem_wdata stable at their last values when mem_we=0.

Reset
REQ-025 SHALL, on rst_n low, immediately set the FSM to OCIOSO, contador=0, mem_we=0, mem_addr=0, mem_wdata=0, cheio=0 and erro=0, and drop any in-flight write.
REQ-026 SHALL, after rst_n deasserts, raise in_ready on the first clock edge.

Configuration
REQ-027 SHALL, with macro FUNCT_CHECK_EN defined, additionally reject (erro, no write) funct combinations other than: ADD 000/0000000, OR 110/0000000, SLL 001/0000000, ADDI 000, LH 001, SH 001 and BNE 001.
REQ-028 SHALL, without FUNCT_CHECK_EN, check the opcode only and pass funct3/funct7 through unchanged.

Structure
REQ-029 SHALL place the opcode constants, funct constants, FSM state typedef and MEM_PALAVRAS default in shared package pacote_rv, which the decoder also uses.
REQ-030 SHALL place the field-to-word packing and legality check in a purely combinational sub-module monta_instrucao.

Verification
REQ-031 SHALL test ADD x3,x1,x2 (opcode 0110011, funct3 0, funct7 0, rd 3, rs1 1, rs2 2) -> mem_we at addr 0, mem_wdata 0x002081B3, contador 1.
REQ-032 SHALL test ADDI x5,x0,12 followed by SH x2,8(x1) -> writes 0x00C00293 at addr 0 and 0x00209423 at addr 4.
REQ-033 SHALL test BNE x1,x2 with imediato 0x010 -> 0x00209863; opcode 0x7F -> erro pulse, no mem_we, contador unchanged.
REQ-034 SHALL test 51 back-to-back legal instructions -> last write at addr 200, cheio=1, in_ready=0, and a 52nd in_valid is ignored.
REQ-035 SHALL test rst_n low during ESCREVE -> no mem_we, all outputs zero; then reinicia while CHEIO -> contador 0 and in_ready=1 next cycle.
REQ-036 SHALL, with FUNCT_CHECK_EN, test OR with funct7 0100000 -> erro and no write; without the macro, the same stimulus is written.

Source files
------------

// File: rtl/codificador_instrucoes_pkg.sv
// Shared RV32 subset constants (pacote_rv): opcodes, funct fields and the encoder FSM states.
// Also used by the decoder, so the field layout here is shared between both blocks.
package pacote_rv;

  localparam int MEM_PALAVRAS_PADRAO = 51;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [6:0] F7_BASE = 7'b0000000;

  typedef enum logic [1:0] {OCIOSO, ESCREVE, CHEIO} estado_t;

  // Supported funct3/funct7 pairs; only consulted when the strict funct check is built in.
  function automatic logic funct_ok(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
    case (op)
      OP_R:    funct_ok = (f7 == F7_BASE) && (f3 == F3_ADD || f3 == F3_OR || f3 == F3_SLL);
      OP_I:    funct_ok = (f3 == F3_ADDI);
      OP_LOAD: funct_ok = (f3 == F3_LH);
      OP_S:    funct_ok = (f3 == F3_SH);
      OP_B:    funct_ok = (f3 == F3_BNE);
      default: funct_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/codificador_instrucoes_if.sv
// Field-set handshake plus instruction-memory write bus of the instruction encoder.
interface codificador_instrucoes_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [11:0] imediato;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cheio;
  logic        erro;
  logic [5:0]  contador;

  modport master (
    output in_valid, opcode, funct3, funct7, rs1, rs2, rd, imediato,
    input  in_ready, mem_we, mem_addr, mem_wdata, cheio, erro, contador
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7, rs1, rs2, rd, imediato,
    output in_ready, mem_we, mem_addr, mem_wdata, cheio, erro, contador
  );
endinterface

// File: rtl/codificador_instrucoes_monta.sv
// monta_instrucao: combinational packing of instruction fields into a 32-bit word plus legality flag.
// Build option FUNCT_CHECK_EN also rejects unsupported funct3/funct7 combinations.
module monta_instrucao
  import pacote_rv::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  input  logic [11:0] imediato_i,
  output logic [31:0] palavra_o,
  output logic        legal_o
);

  logic opcode_ok;

  always_comb begin
    palavra_o = 32'd0;
    opcode_ok = 1'b1;
    case (opcode_i)
      OP_R:          palavra_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      OP_I, OP_LOAD: palavra_o = {imediato_i, rs1_i, funct3_i, rd_i, opcode_i};
      // Store and branch split the immediate around rs2/rs1, mirroring the decoder's extraction
      OP_S, OP_B:    palavra_o = {imediato_i[11:5], rs2_i, rs1_i, funct3_i, imediato_i[4:0], opcode_i};
      default:       opcode_ok = 1'b0;
    endcase
  end

`ifdef FUNCT_CHECK_EN
  assign legal_o = opcode_ok && funct_ok(opcode_i, funct3_i, funct7_i);
`else
  assign legal_o = opcode_ok;
`endif

endmodule

// File: rtl/codificador_instrucoes.sv
// Instruction encoder: accepts field sets, writes encoded words sequentially into instruction memory.
// Optional build macro FUNCT_CHECK_EN tightens the legality check to supported funct codes.
module codificador_instrucoes
  import pacote_rv::*;
#(
  parameter int MEM_PALAVRAS = MEM_PALAVRAS_PADRAO
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reinicia,
  codificador_instrucoes_if.slave bus
);

  localparam logic [5:0] LIMITE = 6'(MEM_PALAVRAS);

  estado_t     estado_q, estado_d;
  logic [5:0]  contador_q, contador_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        erro_q, erro_d;
  logic        pronto_q;
  logic [31:0] palavra;
  logic        legal;
  logic        handshake;

  monta_instrucao u_monta (
    .opcode_i   (bus.opcode),
    .funct3_i   (bus.funct3),
    .funct7_i   (bus.funct7),
    .rs1_i      (bus.rs1),
    .rs2_i      (bus.rs2),
    .rd_i       (bus.rd),
    .imediato_i (bus.imediato),
    .palavra_o  (palavra),
    .legal_o    (legal)
  );

  assign handshake = bus.in_valid && bus.in_ready;

  // pronto_q keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= OCIOSO;
      contador_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      erro_q     <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      erro_q     <= erro_d;
      pronto_q   <= 1'b1;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    erro_d     = 1'b0;
    if (reinicia) begin
      estado_d   = OCIOSO;
      contador_d = '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (handshake) begin
            if (legal) begin
              addr_d   = {24'd0, contador_q, 2'b00};
              wdata_d  = palavra;
              estado_d = ESCREVE;
            end else begin
              erro_d = 1'b1;
            end
          end
        end
        ESCREVE: begin
          contador_d = contador_q + 6'd1;
          estado_d   = (contador_d == LIMITE) ? CHEIO : OCIOSO;
        end
        CHEIO:   estado_d = CHEIO;
        default: estado_d = OCIOSO;
      endcase
    end
  end

  // A restart arriving during the write cycle cancels the strobe
  assign bus.mem_we    = (estado_q == ESCREVE) && !reinicia;
  assign bus.in_ready  = (estado_q == OCIOSO) && pronto_q;
  assign bus.cheio     = (estado_q == CHEIO);
  assign bus.erro      = erro_q;
  assign bus.contador  = contador_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_codificador_instrucoes.sv
// Self-checking bench for codificador_instrucoes: directed vectors plus randomized traffic vs a behavioural model.
module tb_codificador_instrucoes;

  localparam int MEM = 51;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic reinicia = 1'b0;

  codificador_instrucoes_if bus ();

  codificador_instrucoes #(.MEM_PALAVRAS(MEM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .reinicia (reinicia),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(string nome, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nome, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit modelo_legal(int unsigned op, int unsigned f3, int unsigned f7);
    bit ok;
    ok = (op == 'h33 || op == 'h13 || op == 'h03 || op == 'h23 || op == 'h63);
`ifdef FUNCT_CHECK_EN
    if (op == 'h33)      ok = (f7 == 0) && (f3 == 0 || f3 == 6 || f3 == 1);
    else if (op == 'h13) ok = (f3 == 0);
    else if (ok)         ok = (f3 == 1);
`else
    if (f3 > 7 || f7 > 127) ok = 0;
`endif
    return ok;
  endfunction

  function automatic logic [31:0] modelo_palavra(int unsigned op, int unsigned f3, int unsigned f7,
                                                 int unsigned rs1, int unsigned rs2, int unsigned rd,
                                                 int unsigned imm);
    int unsigned w;
    if (op == 'h33)
      w = f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + op;
    else if (op == 'h13 || op == 'h03)
      w = imm * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + op;
    else if (op == 'h23 || op == 'h63)
      w = (imm / 32) * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + (imm % 32) * 128 + op;
    else
      w = 0;
    return w;
  endfunction

  int          m_count   = 0;
  bit          m_pend    = 0;
  bit          m_full    = 0;
  bit          m_err     = 0;
  bit          m_started = 0;
  logic [31:0] m_addr    = 0;
  logic [31:0] m_data    = 0;
  wire         m_pronto  = m_started && !m_full && !m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count <= 0; m_pend <= 0; m_full <= 0; m_err <= 0;
      m_started <= 0; m_addr <= 0; m_data <= 0;
    end else begin
      m_started <= 1;
      m_err     <= 0;
      if (reinicia) begin
        m_count <= 0; m_pend <= 0; m_full <= 0;
      end else if (m_pend) begin
        m_pend  <= 0;
        m_count <= m_count + 1;
        m_full  <= (m_count + 1 == MEM);
      end else if (bus.in_valid && m_pronto) begin
        if (modelo_legal(bus.opcode, bus.funct3, bus.funct7)) begin
          m_pend <= 1;
          m_addr <= m_count * 4;
          m_data <= modelo_palavra(bus.opcode, bus.funct3, bus.funct7, bus.rs1, bus.rs2,
                                   bus.rd, bus.imediato);
        end else begin
          m_err <= 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  32'(bus.in_ready),  32'(m_pronto));
    chk("mem_we",    32'(bus.mem_we),    32'(m_pend && !reinicia));
    chk("mem_addr",  bus.mem_addr,       m_addr);
    chk("mem_wdata", bus.mem_wdata,      m_data);
    chk("erro",      32'(bus.erro),      32'(m_err));
    chk("contador",  32'(bus.contador),  32'(m_count));
    chk("cheio",     32'(bus.cheio),     32'(m_full));
  end

  // ---------------- write/error monitor ----------------
  int          n_wr = 0;
  int          n_err = 0;
  logic [31:0] last_addr = 0;
  logic [31:0] last_data = 0;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      n_wr++;
      last_addr = bus.mem_addr;
      last_data = bus.mem_wdata;
    end
    if (bus.erro) n_err++;
  end

  // ---------------- stimulus ----------------
  logic [6:0] ops_legais [5] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
  logic [2:0] f3_r       [3] = '{3'd0, 3'd6, 3'd1};

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic poe(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic [4:0] s1,
                     logic [4:0] s2, logic [4:0] d, logic [11:0] imm);
    bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
    bus.rs1 = s1; bus.rs2 = s2; bus.rd = d; bus.imediato = imm;
  endtask

  task automatic envia(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic [4:0] s1,
                       logic [4:0] s2, logic [4:0] d, logic [11:0] imm);
    bit hs = 0;
    bit r;
    poe(op, f3, f7, s1, s2, d, imm);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20 && !hs; k++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
      hs = r;
    end
    bus.in_valid = 1'b0;
    if (!hs) chk("handshake_timeout", 32'(hs), 32'd1);
  endtask

  task automatic envia_legal_aleatoria();
    logic [6:0] op;
    logic [2:0] f3;
    int sel;
    sel = $urandom_range(0, 4);
    op  = ops_legais[sel];
    if (op == 7'h33)      f3 = f3_r[$urandom_range(0, 2)];
    else if (op == 7'h13) f3 = 3'd0;
    else                  f3 = 3'd1;
    envia(op, f3, 7'd0, 5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, e;
    bus.in_valid = 1'b0;
    poe(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    #1 rst_n = 1'b0;
    repeat (3) ciclo();
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset_contador", 32'(bus.contador), 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'd0);
    rst_n = 1'b1;
    ciclo();
    chk("in_ready_first_edge", 32'(bus.in_ready), 32'd1);

    // ADD x3,x1,x2
    envia(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 12'd0);
    ciclo();
    chk("add_addr", last_addr, 32'd0);
    chk("add_data", last_data, 32'h002081B3);
    chk("add_contador", 32'(bus.contador), 32'd1);
    chk("add_n_wr", 32'(n_wr), 32'd1);

    reinicia = 1'b1; ciclo(); reinicia = 1'b0;
    chk("reinicia_contador", 32'(bus.contador), 32'd0);

    // ADDI x5,x0,12 ; SH x2,8(x1)
    envia(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 12'd12);
    ciclo();
    chk("addi_addr", last_addr, 32'd0);
    chk("addi_data", last_data, 32'h00C00293);
    envia(7'h23, 3'd1, 7'd0, 5'd1, 5'd2, 5'd0, 12'd8);
    ciclo();
    chk("sh_addr", last_addr, 32'd4);
    chk("sh_data", last_data, 32'h00209423);

    // BNE x1,x2,0x010
    envia(7'h63, 3'd1, 7'd0, 5'd1, 5'd2, 5'd0, 12'h010);
    ciclo();
    chk("bne_addr", last_addr, 32'd8);
    chk("bne_data", last_data, 32'h00209863);

    // Illegal opcode
    w = n_wr; e = n_err;
    envia(7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 12'd0);
    ciclo();
    chk("illegal_erro", 32'(n_err), 32'(e + 1));
    chk("illegal_no_write", 32'(n_wr), 32'(w));
    chk("illegal_contador", 32'(bus.contador), 32'd3);

    // OR with funct7 0100000
    w = n_wr; e = n_err;
    envia(7'h33, 3'd6, 7'h20, 5'd1, 5'd2, 5'd3, 12'd0);
    ciclo();
`ifdef FUNCT_CHECK_EN
    chk("or_f7_erro", 32'(n_err), 32'(e + 1));
    chk("or_f7_no_write", 32'(n_wr), 32'(w));
`else
    chk("or_f7_write", 32'(n_wr), 32'(w + 1));
    chk("or_f7_data", last_data, 32'h4020E1B3);
    chk("or_f7_addr", last_addr, 32'd12);
`endif

    // Fill the memory back-to-back
    reinicia = 1'b1; ciclo(); reinicia = 1'b0;
    w = n_wr;
    for (int i = 0; i < MEM; i++) envia_legal_aleatoria();
    ciclo();
    chk("full_n_wr", 32'(n_wr), 32'(w + MEM));
    chk("full_last_addr", last_addr, 32'd200);
    chk("full_cheio", 32'(bus.cheio), 32'd1);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    w = n_wr;
    poe(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 12'd0);
    bus.in_valid = 1'b1;
    repeat (5) ciclo();
    bus.in_valid = 1'b0;
    chk("full_ignored_write", 32'(n_wr), 32'(w));
    chk("full_contador", 32'(bus.contador), 32'd51);

    // reinicia while full
    reinicia = 1'b1; ciclo(); reinicia = 1'b0;
    chk("restart_full_contador", 32'(bus.contador), 32'd0);
    chk("restart_full_in_ready", 32'(bus.in_ready), 32'd1);

    // rst_n during the write cycle
    w = n_wr;
    envia(7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd7, 12'hABC);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_wr_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_wr_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_wr_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_wr_erro_cheio", {30'd0, bus.erro, bus.cheio}, 32'd0);
    chk("rst_wr_n_wr", 32'(n_wr), 32'(w));
    ciclo();
    rst_n = 1'b1;
    ciclo();

    // reinicia during the write cycle
    w = n_wr;
    envia(7'h33, 3'd1, 7'd0, 5'd4, 5'd5, 5'd6, 12'd0);
    reinicia = 1'b1; ciclo(); reinicia = 1'b0;
    chk("restart_wr_no_write", 32'(n_wr), 32'(w));
    chk("restart_wr_contador", 32'(bus.contador), 32'd0);

    // Randomized traffic, per-cycle stimulus
    for (int c = 0; c < 600; c++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) bus.opcode = ops_legais[$urandom_range(0, 4)];
      else                           bus.opcode = 7'($urandom);
      bus.funct3   = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'($urandom);
      bus.funct7   = ($urandom_range(0, 1) != 0) ? 7'd0 : 7'($urandom);
      bus.rs1      = 5'($urandom);
      bus.rs2      = 5'($urandom);
      bus.rd       = 5'($urandom);
      bus.imediato = 12'($urandom);
      reinicia     = ($urandom_range(0, 149) == 0);
      ciclo();
    end
    bus.in_valid = 1'b0;
    reinicia = 1'b0;
    repeat (3) ciclo();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
